// File: rtl/clip_mem_sequencer.sv
// Clip record/playback sequencer: paces one memory access per sample tick
// over one of two clip blocks, tracking which clips hold a full recording.
module clip_mem_sequencer #(
  parameter int CLK_DIV  = 2500,
  parameter int CLIP_LEN = 80000,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_clip,
  input  logic              abort,
  input  logic [DATA_W-1:0] sample_in,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [1:0]        clip_valid
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OFF_W  = $clog2(CLIP_LEN + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(CLIP_LEN - 1);
  localparam logic [ADDR_W-1:0] CLIP1_BASE = ADDR_W'(CLIP_LEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic              op_q;
  logic              clip_q;
  logic              err_q;
  logic              rd_pend;
  logic [TICK_W-1:0] tick;
  logic [OFF_W-1:0]  offset;
  logic [DATA_W-1:0] hold_q;
  logic [ADDR_W-1:0] base;

  logic accept;
  logic start;
  logic access;
  logic last;

  always_comb begin
    accept   = cmd_valid && (state == IDLE);
    start    = accept && (cmd_op || clip_valid[cmd_clip]);
    access   = (state == RUN) && (tick == TICK_LAST);
    last     = access && (offset == OFF_LAST);
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes are decoded straight from the tick so they drop
  // with the state on an asynchronous reset.
  always_comb begin
    base      = clip_q ? CLIP1_BASE : '0;
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_en    = access;
    mem_we    = access && op_q;
    mem_addr  = access ? base + ADDR_W'(offset) : '0;
    mem_wdata = (access && op_q) ? sample_in : '0;
    done      = (state == FINISH) || err_q;
    cmd_err   = err_q;
  end

  // Read data arrives the cycle after the strobe; pass it through then
  // and keep a copy so the output holds between samples.
  always_comb begin
    sample_out_valid = rd_pend;
    sample_out       = rd_pend ? mem_rdata : hold_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 1'b0;
      clip_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_pend    <= 1'b0;
      tick       <= '0;
      offset     <= '0;
      hold_q     <= '0;
      clip_valid <= 2'b00;
    end else begin
      err_q   <= accept && !start;
      rd_pend <= access && !op_q;
      if (rd_pend) hold_q <= mem_rdata;
      if (start) begin
        op_q   <= cmd_op;
        clip_q <= cmd_clip;
        tick   <= '0;
        offset <= '0;
        if (cmd_op) clip_valid[cmd_clip] <= 1'b0;
      end else if (state == RUN) begin
        tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
        if (access) offset <= offset + 1'b1;
      end
      if ((state == FINISH) && op_q) clip_valid[clip_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clip_mem_sequencer.sv
// Directed bench for clip_mem_sequencer with CLK_DIV=4, CLIP_LEN=8
// and a one-cycle-latency memory model.
module tb_clip_mem_sequencer;

  localparam int DIV = 4;
  localparam int LEN = 8;
  localparam int AW  = 5;
  localparam int DW  = 12;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic          cmd_clip;
  logic          abort;
  logic [DW-1:0] sample_in;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid;
  logic          busy;
  logic          done;
  logic          cmd_err;
  logic [1:0]    clip_valid;

  clip_mem_sequencer #(
    .CLK_DIV (DIV),
    .CLIP_LEN(LEN),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_clip        (cmd_clip),
    .abort           (abort),
    .sample_in       (sample_in),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .busy            (busy),
    .done            (done),
    .cmd_err         (cmd_err),
    .clip_valid      (clip_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:31];
  int cyc    = 0;
  int n_acc  = 0;
  int n_busy = 0;
  int acc_addr[$];
  int acc_we[$];
  int acc_wd[$];
  int acc_cyc[$];
  int sov_data[$];
  int sov_cyc[$];
  int done_cyc[$];

  int            wr_base = 0;
  logic [DW-1:0] sin_off = '0;
  assign sample_in = DW'(n_acc - wr_base) + sin_off;

  always @(posedge clock) begin
    if (mem_en) begin
      acc_addr.push_back(int'(mem_addr));
      acc_we.push_back(int'(mem_we));
      acc_wd.push_back(int'(mem_wdata));
      acc_cyc.push_back(cyc);
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
      n_acc++;
    end
    if (sample_out_valid) begin
      sov_data.push_back(int'(sample_out));
      sov_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) n_busy++;
    cyc++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic op,
                       input logic clip,
                       output int acc);
    cmd_op    = op;
    cmd_clip  = clip;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic check_ops(input string tag, input int ab,
                           input int acc, input int n,
                           input int we, input int a0,
                           input int wd0);
    chk({tag, "_n"}, acc_addr.size() - ab, n);
    for (int k = 0; k < n; k++) begin
      if (ab + k < acc_addr.size()) begin
        chk({tag, "_addr"}, acc_addr[ab+k], a0 + k);
        chk({tag, "_we"}, acc_we[ab+k], we);
        chk({tag, "_cyc"}, acc_cyc[ab+k], acc + 3 + DIV * k);
        if (we != 0) chk({tag, "_wd"}, acc_wd[ab+k], wd0 + k);
      end
    end
  endtask

  task automatic err_play(input string tag);
    int acc;
    int ab;
    int db;
    int bb;
    ab = acc_addr.size();
    db = done_cyc.size();
    bb = n_busy;
    issue(1'b0, 1'b0, acc);
    chk({tag, "_err"}, cmd_err, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    step(1);
    chk({tag, "_err1"}, cmd_err, 0);
    chk({tag, "_done1"}, done, 0);
    step(10);
    chk({tag, "_nacc"}, acc_addr.size() - ab, 0);
    chk({tag, "_ndone"}, done_cyc.size() - db, 1);
    chk({tag, "_nbusy"}, n_busy - bb, 0);
  endtask

  int acc;
  int ab;
  int db;
  int sb;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_clip  = 1'b0;
    abort     = 1'b0;
    step(3);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cv", clip_valid, 0);
    chk("rst_so", sample_out, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    @(negedge clock);
    reset_n = 1'b1;

    err_play("err0");

    // record clip 0, sample k at access k
    ab = acc_addr.size();
    db = done_cyc.size();
    wr_base = n_acc;
    sin_off = 12'h000;
    issue(1'b1, 1'b0, acc);
    chk("r0_busy", busy, 1);
    chk("r0_ready", cmd_ready, 0);
    step(36);
    check_ops("r0", ab, acc, LEN, 1, 0, 0);
    chk("r0_ndone", done_cyc.size() - db, 1);
    if (done_cyc.size() > db)
      chk("r0_dcyc", done_cyc[db], acc + 32);
    chk("r0_cv", clip_valid, 2'b01);
    chk("r0_idle", busy, 0);

    // record clip 1 with commands poked while busy
    ab = acc_addr.size();
    db = done_cyc.size();
    wr_base = n_acc;
    sin_off = 12'h108;
    issue(1'b1, 1'b1, acc);
    step(5);
    cmd_op    = 1'b0;
    cmd_clip  = 1'b0;
    cmd_valid = 1'b1;
    step(1);
    cmd_op = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("r1_cv_mid", clip_valid, 2'b01);
    chk("r1_err_mid", cmd_err, 0);
    step(29);
    check_ops("r1", ab, acc, LEN, 1, LEN, 'h108);
    chk("r1_ndone", done_cyc.size() - db, 1);
    chk("r1_cv", clip_valid, 2'b11);

    // play clip 1
    ab = acc_addr.size();
    db = done_cyc.size();
    sb = sov_data.size();
    issue(1'b0, 1'b1, acc);
    step(36);
    check_ops("p1", ab, acc, LEN, 0, LEN, 0);
    chk("p1_nsov", sov_data.size() - sb, LEN);
    for (int k = 0; k < LEN; k++) begin
      if (sb + k < sov_data.size()) begin
        chk("p1_so", sov_data[sb+k], 'h108 + k);
        chk("p1_socyc", sov_cyc[sb+k], acc + 4 + DIV * k);
      end
    end
    chk("p1_ndone", done_cyc.size() - db, 1);
    if (done_cyc.size() > db)
      chk("p1_dcyc", done_cyc[db], acc + 32);
    chk("p1_hold", sample_out, 'h10f);
    chk("p1_cv", clip_valid, 2'b11);

    // record clip 0, abort after third write
    ab = acc_addr.size();
    db = done_cyc.size();
    issue(1'b1, 1'b0, acc);
    chk("ab_cv0", clip_valid, 2'b10);
    step(12);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_ready", cmd_ready, 1);
    step(30);
    chk("ab_nacc", acc_addr.size() - ab, 3);
    chk("ab_ndone", done_cyc.size() - db, 0);
    chk("ab_cv", clip_valid, 2'b10);

    // play clip 1, reset at offset 5
    db = done_cyc.size();
    issue(1'b0, 1'b1, acc);
    step(24);
    chk("rp_sov_pre", sample_out_valid, 1);
    chk("rp_so_pre", sample_out, 'h10d);
    reset_n = 1'b0;
    #1;
    chk("rp_busy", busy, 0);
    chk("rp_ready", cmd_ready, 1);
    chk("rp_en", mem_en, 0);
    chk("rp_sov", sample_out_valid, 0);
    chk("rp_so", sample_out, 0);
    chk("rp_cv", clip_valid, 0);
    chk("rp_done", done, 0);
    cmd_op    = 1'b1;
    cmd_clip  = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("rp_first_cmd", busy, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("rp_abort", busy, 0);
    step(4);
    chk("rp_ndone", done_cyc.size() - db, 0);

    err_play("err1");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
